peripheral_spi_slave: RTL and testbench



---
 rtl/peripheral_spi_slave_pkg.sv | 19 +
 rtl/peripheral_spi_slave_if.sv | 28 ++
 rtl/peripheral_spi_slave_spi_slave.sv | 152 +++++++++++++++
 rtl/peripheral_spi_slave.sv | 108 ++++++++++
 tb/tb_peripheral_spi_slave.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/peripheral_spi_slave_pkg.sv
// Shared definitions for the SPI slave peripheral: register addresses,
// frame width and core FSM state encoding.
package spi_slave_pkg;

  localparam int unsigned FRAME_BITS = 8;

  localparam logic [3:0] ADDR_TXD  = 4'h0;
  localparam logic [3:0] ADDR_CTRL = 4'h2;
  localparam logic [3:0] ADDR_RXD  = 4'h4;
  localparam logic [3:0] ADDR_BUSY = 4'h6;
  localparam logic [3:0] ADDR_NEW  = 4'h8;
  localparam logic [3:0] ADDR_STAT = 4'hA;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/peripheral_spi_slave_if.sv
// CPU register bus plus external SPI pins of the SPI slave peripheral.
//   d_in/cs/addr/rd/wr : CPU write data, select, address, strobes
//   d_out              : registered read data
//   ss/sck/mosi        : pins driven by the external SPI master
//   miso/miso_oe       : slave data out and its output enable
interface peripheral_spi_slave_if;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        ss;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        miso_oe;

  modport master (
    output d_in, cs, addr, rd, wr, ss, sck, mosi,
    input  d_out, miso, miso_oe
  );

  modport slave (
    input  d_in, cs, addr, rd, wr, ss, sck, mosi,
    output d_out, miso, miso_oe
  );
endinterface

// File: rtl/peripheral_spi_slave_spi_slave.sv
// SPI mode-0 slave core: pin synchronizers, edge detection, frame FSM
// and shift registers.
//   ss_i/sck_i/mosi_i : asynchronous SPI pins
//   tx_buf_i          : byte to transmit, sampled on tx_load_o
//   tx_load_o         : strobe, tx_shift is loaded from tx_buf_i this cycle
//   rx_data_o         : received shift register contents
//   frame_done_o      : one-cycle pulse, rx_data_o holds a complete frame
//   busy_o, miso_o, miso_oe_o : registered status and pin outputs
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = spi_slave_pkg::FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ss_i,
  input  logic                  sck_i,
  input  logic                  mosi_i,
  input  logic [FRAME_BITS-1:0] tx_buf_i,
  output logic                  tx_load_o,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  frame_done_o,
  output logic                  busy_o,
  output logic                  miso_o,
  output logic                  miso_oe_o
);

  localparam int unsigned CW = $clog2(FRAME_BITS);

  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
  logic ss_dly_q, sck_dly_q;
  logic ss_s, sck_s, mosi_s;
  logic ss_fall, ss_rise, sck_rise, sck_fall;

  spi_state_e             state_q, state_d;
  logic [FRAME_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic [FRAME_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   reload_q, reload_d;
  logic                   frame_done_q, frame_done_d;
  logic                   busy_q, miso_q, miso_oe_q;
  logic                   tx_load;

  // ss idles high so reset does not fabricate a frame start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_dly_q    <= 1'b1;
      sck_dly_q   <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      ss_dly_q    <= ss_s;
      sck_dly_q   <= sck_s;
    end
  end

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ss_dly_q & ~ss_s;
  assign ss_rise  = ~ss_dly_q & ss_s;
  assign sck_rise = ~sck_dly_q & sck_s;
  assign sck_fall = sck_dly_q & ~sck_s;

  // bit_cnt wraps on the last bit rather than holding FRAME_BITS for a cycle;
  // reload_q defers the next tx_buf load to the following sck falling edge.
  always_comb begin
    state_d      = state_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    bit_cnt_d    = bit_cnt_q;
    reload_d     = reload_q;
    frame_done_d = 1'b0;
    tx_load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_shift_d = tx_buf_i;
          tx_load    = 1'b1;
          bit_cnt_d  = '0;
          reload_d   = 1'b0;
          state_d    = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          bit_cnt_d = '0;
          reload_d  = 1'b0;
          state_d   = IDLE;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[FRAME_BITS-2:0], mosi_s};
            if (bit_cnt_q == CW'(FRAME_BITS - 1)) begin
              bit_cnt_d    = '0;
              frame_done_d = 1'b1;
              reload_d     = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (sck_fall) begin
            if (reload_q) begin
              tx_shift_d = tx_buf_i;
              tx_load    = 1'b1;
              reload_d   = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      bit_cnt_q    <= '0;
      reload_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      miso_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      bit_cnt_q    <= bit_cnt_d;
      reload_q     <= reload_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d == ACTIVE);
      miso_q       <= (state_d == ACTIVE) & tx_shift_d[FRAME_BITS-1];
      miso_oe_q    <= (state_d == ACTIVE);
    end
  end

  assign tx_load_o    = tx_load;
  assign rx_data_o    = rx_shift_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;
  assign miso_o       = miso_q;
  assign miso_oe_o    = miso_oe_q;

endmodule

// File: rtl/peripheral_spi_slave.sv
// Memory-mapped SPI slave peripheral: address decode, CPU-visible
// registers and flags, registered read mux.
//   clk, rst : system clock, asynchronous active-low reset
//   bus      : CPU register bus and SPI pins (slave modport)
module peripheral_spi_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = spi_slave_pkg::FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  peripheral_spi_slave_if.slave  bus
);

  logic [FRAME_BITS-1:0] tx_buf_q, tx_buf_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  tx_empty_q, tx_empty_d;
  logic                  new_data_q, new_data_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           d_out_q, d_out_d;

  logic                  tx_load, frame_done, busy;
  logic [FRAME_BITS-1:0] rx_shift;
  logic                  rd_en, wr_en, rd_rxd;

  spi_slave #(
    .FRAME_BITS  (FRAME_BITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_core (
    .clk          (clk),
    .rst          (rst),
    .ss_i         (bus.ss),
    .sck_i        (bus.sck),
    .mosi_i       (bus.mosi),
    .tx_buf_i     (tx_buf_q),
    .tx_load_o    (tx_load),
    .rx_data_o    (rx_shift),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .miso_o       (bus.miso),
    .miso_oe_o    (bus.miso_oe)
  );

  assign rd_en  = bus.cs & bus.rd;
  assign wr_en  = bus.cs & bus.wr;
  assign rd_rxd = rd_en && (bus.addr == ADDR_RXD);

  // A read of rx_data in the completion cycle frees the slot first, so the
  // new frame is accepted and new_data stays set; a CPU write to tx_buf beats
  // a concurrent tx_load for tx_empty.
  always_comb begin
    tx_buf_d   = tx_buf_q;
    tx_empty_d = tx_empty_q;
    rx_data_d  = rx_data_q;
    new_data_d = new_data_q;
    overrun_d  = overrun_q;
    d_out_d    = '0;

    if (tx_load) tx_empty_d = 1'b1;
    if (wr_en && (bus.addr == ADDR_TXD)) begin
      tx_buf_d   = bus.d_in[FRAME_BITS-1:0];
      tx_empty_d = 1'b0;
    end
    if (wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[1]) overrun_d = 1'b0;

    if (rd_rxd) new_data_d = 1'b0;
    if (frame_done) begin
      if (!new_data_q || rd_rxd) begin
        rx_data_d  = rx_shift;
        new_data_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (rd_en) begin
      case (bus.addr)
        ADDR_RXD:  d_out_d = 16'(rx_data_q);
        ADDR_BUSY: d_out_d = {15'b0, busy};
        ADDR_NEW:  d_out_d = {15'b0, new_data_q};
        ADDR_STAT: d_out_d = {14'b0, overrun_q, tx_empty_q};
        default:   d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_buf_q   <= '0;
      tx_empty_q <= 1'b1;
      rx_data_q  <= '0;
      new_data_q <= 1'b0;
      overrun_q  <= 1'b0;
      d_out_q    <= '0;
    end else begin
      tx_buf_q   <= tx_buf_d;
      tx_empty_q <= tx_empty_d;
      rx_data_q  <= rx_data_d;
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
      d_out_q    <= d_out_d;
    end
  end

  assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_peripheral_spi_slave.sv
module tb_peripheral_spi_slave;
  import spi_slave_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  peripheral_spi_slave_if bus ();

  peripheral_spi_slave #(
    .FRAME_BITS  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rd_at_done_val;
  logic [7:0]  got;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_read(input logic [3:0] a, input logic sel, input logic [15:0] exp,
                          input string tag);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.cs = sel; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0; bus.rd = 1'b0;
    chk(tag, bus.d_out, exp_q.pop_front());
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic spi_start();
    @(negedge clk);
    bus.ss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (4) @(negedge clk);
    bus.ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Mode 0 at sck = clk/8; optional rx_data read in the completion cycle.
  task automatic spi_bits(input logic [7:0] m, input int nbits, input bit rd_done,
                          output logic [7:0] g);
    g = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = m[7-i];
      repeat (4) @(negedge clk);
      g[7-i] = bus.miso;
      bus.sck = 1'b1;
      if (rd_done && i == 7) begin
        repeat (3) @(negedge clk);
        bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = ADDR_RXD;
        @(negedge clk);
        bus.cs = 1'b0; bus.rd = 1'b0;
        rd_at_done_val = bus.d_out;
      end else begin
        repeat (4) @(negedge clk);
      end
      bus.sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [7:0] m, input logic [7:0] exp_miso, input bit rd_done,
                           input string tag);
    logic [7:0] g;
    exp_q.push_back({8'h00, exp_miso});
    spi_bits(m, 8, rd_done, g);
    chk(tag, {8'h00, g}, exp_q.pop_front());
  endtask

  initial begin
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;
    bus.ss = 1'b1; bus.sck = 1'b0; bus.mosi = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dout", bus.d_out, 16'h0000);
    chk("reset_miso", {15'b0, bus.miso}, 16'h0000);
    chk("reset_oe", {15'b0, bus.miso_oe}, 16'h0000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "reset_stat");
    cpu_read(ADDR_NEW,  1'b1, 16'h0000, "reset_new");
    cpu_read(ADDR_BUSY, 1'b1, 16'h0000, "reset_busy");
    cpu_read(ADDR_RXD,  1'b1, 16'h0000, "reset_rxd");

    // Basic frame
    cpu_write(ADDR_TXD, 16'h00A5);
    cpu_read(ADDR_STAT, 1'b1, 16'h0000, "txd_clears_empty");
    spi_start();
    cpu_read(ADDR_BUSY, 1'b1, 16'h0001, "busy_in_frame");
    spi_frame(8'h3C, 8'hA5, 1'b0, "miso_a5");
    spi_stop();
    cpu_read(ADDR_NEW,  1'b1, 16'h0001, "new_set");
    cpu_read(ADDR_RXD,  1'b1, 16'h003C, "rxd_3c");
    cpu_read(ADDR_NEW,  1'b1, 16'h0000, "new_cleared");
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "empty_after_load");

    // Back-to-back frames, stale tx_buf reloaded, overrun
    cpu_write(ADDR_TXD, 16'h0077);
    spi_start();
    spi_frame(8'h11, 8'h77, 1'b0, "b2b_miso1");
    spi_frame(8'h22, 8'h77, 1'b0, "b2b_miso2_stale");
    spi_stop();
    cpu_read(ADDR_STAT, 1'b1, 16'h0003, "overrun_set");
    cpu_read(ADDR_NEW,  1'b1, 16'h0001, "b2b_new");
    cpu_write(ADDR_CTRL, 16'h0002);
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "overrun_cleared");
    cpu_read(ADDR_RXD,  1'b1, 16'h0011, "b2b_rxd_first");

    // Aborted frame
    spi_start();
    spi_bits(8'hFF, 5, 1'b0, got);
    bus.ss = 1'b1;
    repeat (2) @(negedge clk);
    cpu_read(ADDR_BUSY, 1'b1, 16'h0000, "abort_busy");
    cpu_read(ADDR_NEW,  1'b1, 16'h0000, "abort_new");
    cpu_read(ADDR_RXD,  1'b1, 16'h0011, "abort_rxd");
    repeat (4) @(negedge clk);

    // rx_data read in the completion cycle
    spi_start();
    spi_frame(8'h5A, 8'h77, 1'b1, "coinc_miso");
    spi_stop();
    chk("coinc_read_old", rd_at_done_val, 16'h0011);
    cpu_read(ADDR_NEW,  1'b1, 16'h0001, "coinc_new");
    cpu_read(ADDR_RXD,  1'b1, 16'h005A, "coinc_rxd");
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "coinc_no_overrun");

    // Reset mid-frame
    cpu_write(ADDR_TXD, 16'h00FF);
    spi_start();
    spi_bits(8'h81, 3, 1'b0, got);
    bus.mosi = 1'b0;
    repeat (2) @(negedge clk);
    chk("midframe_oe", {15'b0, bus.miso_oe}, 16'h0001);
    chk("midframe_miso", {15'b0, bus.miso}, 16'h0001);
    rst = 1'b0;
    #1;
    chk("rst_miso", {15'b0, bus.miso}, 16'h0000);
    chk("rst_oe", {15'b0, bus.miso_oe}, 16'h0000);
    chk("rst_dout", bus.d_out, 16'h0000);
    bus.ss = 1'b1; bus.sck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "rst_stat");
    cpu_read(ADDR_NEW,  1'b1, 16'h0000, "rst_new");
    cpu_read(ADDR_RXD,  1'b1, 16'h0000, "rst_rxd");
    spi_start();
    spi_frame(8'h81, 8'h00, 1'b0, "post_rst_miso");
    spi_stop();
    cpu_read(ADDR_NEW,  1'b1, 16'h0001, "post_rst_new");
    cpu_read(ADDR_RXD,  1'b1, 16'h0081, "post_rst_rxd");

    // Unmapped and unselected reads
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "stat_before_unmapped");
    cpu_read(4'hE,      1'b1, 16'h0000, "unmapped_e");
    cpu_read(ADDR_STAT, 1'b1, 16'h0001, "stat_before_nocs");
    cpu_read(ADDR_STAT, 1'b0, 16'h0000, "read_no_cs");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
